// File: rtl/sumador_serial.sv
// Bit-serial adder: one full-adder bit per cycle, LSB first. The result is ready N cycles after
// start is accepted. Optional subtract mode is enabled by defining SUMADOR_SERIAL_RESTA_EN.
module sumador_serial #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
`ifdef SUMADOR_SERIAL_RESTA_EN
  input  logic         resta,
`endif
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StSuma, StFin} state_e;

  state_e          r_state, w_state_d;
  logic [N-1:0]    r_a, r_b, r_res, r_s;
  logic [CW-1:0]   r_cnt;
  logic            r_carry, r_c_out;
  logic            w_accept, w_last, w_b0, w_sum, w_carry;
  logic [N-1:0]    w_res_next;

`ifdef SUMADOR_SERIAL_RESTA_EN
  logic r_resta;
  // Two's-complement subtraction: invert B bit by bit, carry-in forced to 1.
  assign w_b0 = r_b[0] ^ r_resta;
`else
  assign w_b0 = r_b[0];
`endif

  assign w_accept   = start && (r_state != StSuma);
  assign w_last     = (r_cnt == CW'(N - 1));
  assign w_sum      = r_a[0] ^ w_b0 ^ r_carry;
  assign w_carry    = (r_a[0] & w_b0) | (r_a[0] & r_carry) | (w_b0 & r_carry);
  // New sum bit enters at the MSB; after N shifts bit 0 of the sum sits at bit 0.
  assign w_res_next = (r_res >> 1) | (N'(w_sum) << (N - 1));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_d = StSuma;
      StSuma:  if (w_last) w_state_d = StFin;
      StFin:   w_state_d = start ? StSuma : StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
`ifdef SUMADOR_SERIAL_RESTA_EN
      r_resta <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_res <= '0;
        r_cnt <= '0;
`ifdef SUMADOR_SERIAL_RESTA_EN
        r_resta <= resta;
        r_carry <= resta ? 1'b1 : c_in;
`else
        r_carry <= c_in;
`endif
      end else if (r_state == StSuma) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_res   <= w_res_next;
        r_carry <= w_carry;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_s     <= w_res_next;
          r_c_out <= w_carry;
        end
      end
    end
  end

  assign s     = r_s;
  assign c_out = r_c_out;
  assign busy  = (r_state == StSuma);
  assign done  = (r_state == StFin);

endmodule

// File: tb/tb_sumador_serial.sv
// Directed bench for sumador_serial (N=8): vector table plus multi-cycle corner sequences.
module tb_sumador_serial;

  logic       clk = 1'b0;
  logic       rst_n, start, c_in;
  logic [7:0] a, b, s;
  logic       c_out, busy, done;
`ifdef SUMADOR_SERIAL_RESTA_EN
  logic       resta = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sumador_serial #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef SUMADOR_SERIAL_RESTA_EN
    .resta (resta),
`endif
    .s     (s),
    .c_out (c_out),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_s;
    logic       exp_c;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse start for one cycle, then wait (bounded) for done.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                       output int busy_cyc, output int edges, output bit got_done);
    @(negedge clk);
    a = ta; b = tb_v; c_in = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    busy_cyc = 0;
    got_done = 1'b0;
    while (!got_done && edges < 30) begin
      if (busy) busy_cyc++;
      if (done) got_done = 1'b1;
      else begin
        @(negedge clk);
        edges++;
      end
    end
  endtask

  vec_t vecs[7];
  int   bc, ed, cyc, k, ndone;
  bit   gd;
  logic [7:0] bb_a[3], bb_b[3], bb_s[3];
  logic       bb_c[3], bb_ci[3];

  initial begin
    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_s", 32'(s), 32'h0);
    check("reset_c_out", 32'(c_out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, bc, ed, gd);
      check($sformatf("vec%0d_done_seen", i), 32'(gd), 32'h1);
      check($sformatf("vec%0d_s", i), 32'(s), 32'(vecs[i].exp_s));
      check($sformatf("vec%0d_c_out", i), 32'(c_out), 32'(vecs[i].exp_c));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd8);
      check($sformatf("vec%0d_edges_incl_start", i), 32'(ed), 32'd9);
      @(negedge clk);
      check($sformatf("vec%0d_done_one_cycle", i), 32'(done), 32'h0);
      check($sformatf("vec%0d_idle_not_busy", i), 32'(busy), 32'h0);
      check($sformatf("vec%0d_s_hold", i), 32'(s), 32'(vecs[i].exp_s));
    end

    // start pulsed on the 4th busy cycle must be ignored
    @(negedge clk);
    a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("ign_in_busy", 32'(busy), 32'h1);
    a = 8'hF0; b = 8'hF0; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ndone++;
        check("ign_s", 32'(s), 32'h02);
        check("ign_c_out", 32'(c_out), 32'h0);
      end
      @(negedge clk);
    end
    check("ign_done_count", 32'(ndone), 32'd1);

    // back-to-back with start held high
    bb_a = '{8'h12, 8'hF0, 8'h01}; bb_b = '{8'h34, 8'h20, 8'hFE};
    bb_ci = '{1'b0, 1'b0, 1'b1};
    bb_s = '{8'h46, 8'h10, 8'h00}; bb_c = '{1'b0, 1'b1, 1'b1};
    @(negedge clk);
    a = bb_a[0]; b = bb_b[0]; c_in = bb_ci[0]; start = 1'b1;
    k = 0; cyc = 0;
    for (int i = 0; i < 60 && k < 3; i++) begin
      @(negedge clk);
      cyc++;
      if (busy && k > 0 && cyc == 5)
        check($sformatf("b2b%0d_s_hold_in_suma", k), 32'(s), 32'(bb_s[k-1]));
      if (done) begin
        check($sformatf("b2b%0d_s", k), 32'(s), 32'(bb_s[k]));
        check($sformatf("b2b%0d_c_out", k), 32'(c_out), 32'(bb_c[k]));
        check($sformatf("b2b%0d_period", k), 32'(cyc), 32'd9);
        cyc = 0;
        k++;
        if (k < 3) begin
          a = bb_a[k]; b = bb_b[k]; c_in = bb_ci[k];
        end else start = 1'b0;
      end
    end
    check("b2b_all_done", 32'(k), 32'd3);
    start = 1'b0;

    // reset on the 3rd busy cycle aborts; no done follows
    @(negedge clk);
    a = 8'h5A; b = 8'h33; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_done", 32'(done), 32'h0);
    check("rst_mid_s", 32'(s), 32'h0);
    check("rst_mid_c_out", 32'(c_out), 32'h0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("rst_mid_no_activity", 32'(ndone), 32'd0);

    // reset wins over start in the same cycle
    rst_n = 1'b0; start = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    check("rst_prio_busy", 32'(busy), 32'h0);

`ifdef SUMADOR_SERIAL_RESTA_EN
    resta = 1'b1;
    do_op(8'h10, 8'h01, 1'b0, bc, ed, gd);
    check("sub0_s", 32'(s), 32'h0F);
    check("sub0_c_out", 32'(c_out), 32'h1);
    do_op(8'h00, 8'h01, 1'b0, bc, ed, gd);
    check("sub1_s", 32'(s), 32'hFF);
    check("sub1_c_out", 32'(c_out), 32'h0);
    resta = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
